voltage_converter: RTL

//  Consumer of the 0 V calibration result. Latches the zero-volt ADC code once

---
 rtl/voltage_converter_if.sv | 35 +++
 rtl/voltage_converter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/voltage_converter_if.sv
// -----------------------------------------------------------------------------
// voltage_converter_if
//   Bundles the ADC/calibration inputs and the display-facing voltage outputs
//   of voltage_converter.
//   master : drives ad_data, voc_finish, voc_data; observes the volt_* outputs
//   slave  : the converter itself
//   ad_data    raw ADC sample, one per clock
//   voc_finish calibration done (level, sticky until reset)
//   voc_data   calibrated 0 V ADC code
//   volt_sign  1 = negative voltage
//   volt_mv    |voltage| in mV, binary
//   volt_bcd   |voltage| in mV, 5 BCD digits, [19:16] = ten-thousands
//   volt_valid one-cycle pulse when the outputs update
// -----------------------------------------------------------------------------
interface voltage_converter_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] ad_data;
   logic             voc_finish;
   logic [WIDTH-1:0] voc_data;
   logic             volt_sign;
   logic [16:0]      volt_mv;
   logic [19:0]      volt_bcd;
   logic             volt_valid;

   modport master (
      output ad_data, voc_finish, voc_data,
      input  volt_sign, volt_mv, volt_bcd, volt_valid
   );

   modport slave (
      input  ad_data, voc_finish, voc_data,
      output volt_sign, volt_mv, volt_bcd, volt_valid
   );
endinterface

// File: rtl/voltage_converter.sv
// -----------------------------------------------------------------------------
// voltage_converter
//   Latches the 0 V calibration code once calibration completes, then averages
//   blocks of 2^AVG_LOG2 ADC samples, removes the offset, scales the result to
//   signed millivolts and converts the magnitude to 5 BCD digits.
//   Ports:
//     clk    system clock, one ADC sample per cycle
//     rst_n  asynchronous active-low reset
//     bus    voltage_converter_if.slave (ADC/calibration in, voltage out)
//   Flow: IDLE -> ACC (N cycles) -> CALC (2) -> BCD (17) -> DONE (1) -> ACC ...
//   Dropping voc_finish in any non-IDLE state aborts to IDLE without a pulse.
// -----------------------------------------------------------------------------
module voltage_converter #(
   parameter int WIDTH       = 8,
   parameter int AVG_LOG2    = 4,
   parameter int SCALE_NUM   = 20000,
   parameter int SCALE_SHIFT = 8
) (
   input logic                clk,
   input logic                rst_n,
   voltage_converter_if.slave bus
);

   localparam int N      = 1 << AVG_LOG2;
   localparam int SUM_W  = WIDTH + AVG_LOG2;
   localparam int PROD_W = WIDTH + 16;
   localparam int MV_MAX = 99999;
   localparam int CNT_W  = (AVG_LOG2 + 1 > 5) ? AVG_LOG2 + 1 : 5;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ACC  = 3'd1;
   localparam logic [2:0] S_CALC = 3'd2;
   localparam logic [2:0] S_BCD  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]       state_q,      state_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;
   logic [SUM_W-1:0] sum_q,        sum_d;
   logic [WIDTH-1:0] offset_q,     offset_d;
   logic [WIDTH-1:0] mag_q,        mag_d;
   logic             neg_q,        neg_d;
   logic [16:0]      mv_q,         mv_d;
   logic [16:0]      bin_q,        bin_d;
   logic [19:0]      bcd_q,        bcd_d;
   logic             volt_sign_q,  volt_sign_d;
   logic [16:0]      volt_mv_q,    volt_mv_d;
   logic [19:0]      volt_bcd_q,   volt_bcd_d;
   logic             volt_valid_q, volt_valid_d;

   // Datapath helpers
   logic [SUM_W:0]        avg_sum;
   logic [SUM_W:0]        avg_raw;
   logic [WIDTH-1:0]      avg_sat;
   logic signed [WIDTH:0] diff;
   logic [PROD_W:0]       prod;
   logic [PROD_W:0]       scaled;
   logic [16:0]           mv_calc;
   logic [19:0]           bcd_adj;
   logic [36:0]           dabble;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned; that is what keeps this block free of inferred latches.
      state_d      = state_q;
      cnt_d        = cnt_q;
      sum_d        = sum_q;
      offset_d     = offset_q;
      mag_d        = mag_q;
      neg_d        = neg_q;
      mv_d         = mv_q;
      bin_d        = bin_q;
      bcd_d        = bcd_q;
      volt_sign_d  = volt_sign_q;
      volt_mv_d    = volt_mv_q;
      volt_bcd_d   = volt_bcd_q;
      volt_valid_d = 1'b0;

      // Rounded average (half up), saturated to the ADC code range.
      avg_sum = (SUM_W + 1)'(sum_q) + (SUM_W + 1)'(N / 2);
      avg_raw = avg_sum >> AVG_LOG2;
      if (avg_raw > (SUM_W + 1)'((1 << WIDTH) - 1)) begin
         avg_sat = '1;
      end else begin
         avg_sat = avg_raw[WIDTH-1:0];
      end
      diff = $signed({1'b0, avg_sat}) - $signed({1'b0, offset_q});

      // Magnitude to mV with round-half-up, clamped to five digits.
      prod   = (PROD_W + 1)'(mag_q) * (PROD_W + 1)'(SCALE_NUM);
      prod   = prod + ((PROD_W + 1)'(1) << (SCALE_SHIFT - 1));
      scaled = prod >> SCALE_SHIFT;
      if (scaled > (PROD_W + 1)'(MV_MAX)) begin
         mv_calc = 17'(MV_MAX);
      end else begin
         mv_calc = scaled[16:0];
      end

      // Double-dabble step: add 3 to any digit >= 5, then shift one bit in.
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      dabble = {bcd_adj, bin_q} << 1;

      if (state_q != S_IDLE && !bus.voc_finish) begin
         // Calibration lost: discard the partial result, keep the outputs.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.voc_finish) begin
                  offset_d = bus.voc_data;
                  sum_d    = '0;
                  cnt_d    = '0;
                  state_d  = S_ACC;
               end
            end
            S_ACC: begin
               sum_d = sum_q + SUM_W'(bus.ad_data);
               if (cnt_q == CNT_W'(N - 1)) begin
                  cnt_d   = '0;
                  state_d = S_CALC;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_CALC: begin
               if (cnt_q == '0) begin
                  neg_d = diff[WIDTH];
                  mag_d = diff[WIDTH] ? WIDTH'(-diff) : diff[WIDTH-1:0];
                  cnt_d = CNT_W'(1);
               end else begin
                  mv_d    = mv_calc;
                  bin_d   = mv_calc;
                  bcd_d   = '0;
                  cnt_d   = '0;
                  state_d = S_BCD;
               end
            end
            S_BCD: begin
               bcd_d = dabble[36:17];
               bin_d = dabble[16:0];
               if (cnt_q == CNT_W'(16)) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               volt_mv_d    = mv_q;
               volt_bcd_d   = bcd_q;
               // A zero reading is never reported as negative.
               volt_sign_d  = neg_q & (mv_q != '0);
               volt_valid_d = 1'b1;
               sum_d        = '0;
               cnt_d        = '0;
               state_d      = S_ACC;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   // NOTE: every register here is reset, datapath included, because the
   // outputs must read 0 during and right after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         sum_q        <= '0;
         offset_q     <= '0;
         mag_q        <= '0;
         neg_q        <= 1'b0;
         mv_q         <= '0;
         bin_q        <= '0;
         bcd_q        <= '0;
         volt_sign_q  <= 1'b0;
         volt_mv_q    <= '0;
         volt_bcd_q   <= '0;
         volt_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sum_q        <= sum_d;
         offset_q     <= offset_d;
         mag_q        <= mag_d;
         neg_q        <= neg_d;
         mv_q         <= mv_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         volt_sign_q  <= volt_sign_d;
         volt_mv_q    <= volt_mv_d;
         volt_bcd_q   <= volt_bcd_d;
         volt_valid_q <= volt_valid_d;
      end
   end

   assign bus.volt_sign  = volt_sign_q;
   assign bus.volt_mv    = volt_mv_q;
   assign bus.volt_bcd   = volt_bcd_q;
   assign bus.volt_valid = volt_valid_q;

endmodule
